// File: rtl/fht_adc_loader.sv
// ADC sample loader for fht_top: packs a stream of signed samples row-major into
// four RAM banks, then pulses oSTART and waits for the transform to report ready.
module fht_adc_loader #(
    parameter int D_BIT     = 24,
    parameter int A_BIT     = 8,
    parameter int ADC_WIDTH = 12
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [ADC_WIDTH-1:0] iADC_DATA,
    input  logic                 iADC_VALID,
    output logic                 oADC_READY,
    output logic [3:0]           oWE,
    output logic [D_BIT-1:0]     oDATA,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic                 oSTART,
    input  logic                 iFHT_RDY,
    output logic [15:0]          oFRAME_CNT,
    output logic                 oBUSY
);
    localparam int CNT_W = A_BIT + 2;

    typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       hold;
    logic             armed;
    logic             accept;
    logic             last;
    logic             wait_done;

    // armed keeps ready low while reset is held and through the release edge
    assign oADC_READY = armed && (state == LOAD);
    assign oBUSY      = (state != LOAD);
    assign accept     = iADC_VALID && oADC_READY;
    assign last       = &cnt;
    assign wait_done  = (hold == 2'd2) && iFHT_RDY;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && last) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (wait_done) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= LOAD;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    // low bits select the bank, high bits the row; wraps to 0 on the last sample
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            cnt <= '0;
        end else if (state == WAIT && wait_done) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    // holdoff counts WAIT cycles; iFHT_RDY is only honoured once it saturates
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            hold <= '0;
        end else if (state != WAIT) begin
            hold <= '0;
        end else if (hold != 2'd2) begin
            hold <= hold + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oSTART     <= 1'b0;
            oFRAME_CNT <= '0;
        end else begin
            oSTART <= (state == START);
            if (state == WAIT && wait_done) oFRAME_CNT <= oFRAME_CNT + 16'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oWE      <= '0;
            oDATA    <= '0;
            oADDR_WR <= '0;
        end else begin
            oWE <= accept ? (4'b0001 << cnt[1:0]) : 4'b0000;
            if (accept) begin
                oDATA    <= {iADC_DATA, {(D_BIT-ADC_WIDTH){1'b0}}};
                oADDR_WR <= cnt[CNT_W-1:2];
            end
        end
    end

endmodule

// File: tb/tb_fht_adc_loader.sv
// Randomized bench for fht_adc_loader (BANK_SIZE=8): every cycle the outputs are
// compared with a frame-level reference model driven by the same stimulus.
module tb_fht_adc_loader;
    localparam int D_BIT = 24, A_BIT = 3, ADC_WIDTH = 12;
    localparam int FRAME = 4 * (2 ** A_BIT);

    logic                 iCLK = 1'b0;
    logic                 iRESET = 1'b0;
    logic [ADC_WIDTH-1:0] iADC_DATA = '0;
    logic                 iADC_VALID = 1'b0;
    logic                 oADC_READY;
    logic [3:0]           oWE;
    logic [D_BIT-1:0]     oDATA;
    logic [A_BIT-1:0]     oADDR_WR;
    logic                 oSTART;
    logic                 iFHT_RDY = 1'b0;
    logic [15:0]          oFRAME_CNT;
    logic                 oBUSY;

    fht_adc_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .ADC_WIDTH(ADC_WIDTH)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iADC_DATA(iADC_DATA), .iADC_VALID(iADC_VALID),
        .oADC_READY(oADC_READY), .oWE(oWE), .oDATA(oDATA), .oADDR_WR(oADDR_WR),
        .oSTART(oSTART), .iFHT_RDY(iFHT_RDY), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0, n_err = 0;
    int cyc = 0, nstart = 0, start_cyc = -1, load_cyc = -1;
    logic prev_busy = 1'b0;

    // model: phase 0 = collecting samples, 1 = last write on the bus, 2 = transform running
    int              m_phase, m_k, m_wcyc;
    bit              m_armed;
    logic [3:0]      m_we;
    logic [D_BIT-1:0] m_data;
    logic [A_BIT-1:0] m_addr;
    logic            m_start;
    logic [15:0]     m_fcnt;

    logic [ADC_WIDTH-1:0] spec_v [4] = '{12'h7FF, 12'h800, 12'h001, 12'hFFF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("we",    32'(oWE), 32'(m_we));
        chk("data",  32'(oDATA), 32'(m_data));
        chk("addr",  32'(oADDR_WR), 32'(m_addr));
        chk("start", 32'(oSTART), 32'(m_start));
        chk("busy",  32'(oBUSY), 32'(m_phase != 0));
        chk("ready", 32'(oADC_READY), 32'(m_phase == 0 && m_armed));
        chk("fcnt",  32'(oFRAME_CNT), 32'(m_fcnt));
    endtask

    task automatic model_update(input logic v, input logic [ADC_WIDTH-1:0] d, input logic r);
        bit acc;
        acc     = v && m_phase == 0 && m_armed;
        m_we    = '0;
        m_start = 1'b0;
        case (m_phase)
            0: if (acc) begin
                m_we   = 4'(1 << (m_k % 4));
                m_data = {d, 12'h000};
                m_addr = A_BIT'(m_k / 4);
                m_k++;
                if (m_k == FRAME) begin
                    m_k     = 0;
                    m_phase = 1;
                end
            end
            1: begin
                m_start = 1'b1;
                m_phase = 2;
                m_wcyc  = 0;
            end
            default: if (m_wcyc >= 2 && r) begin
                m_phase = 0;
                m_fcnt  = m_fcnt + 16'd1;
            end else begin
                m_wcyc++;
            end
        endcase
        m_armed = 1'b1;
    endtask

    task automatic step(input logic v, input logic [ADC_WIDTH-1:0] d, input logic r);
        @(negedge iCLK);
        cyc++;
        compare_all();
        if (oSTART) begin
            nstart++;
            start_cyc = cyc;
        end
        if (prev_busy && !oBUSY) load_cyc = cyc;
        prev_busy  = oBUSY;
        iADC_VALID = v;
        iADC_DATA  = d;
        iFHT_RDY   = r;
        model_update(v, d, r);
    endtask

    // asserts reset now (any phase of the clock) and releases it on a falling edge
    task automatic do_reset();
        iRESET = 1'b0;
        #1;
        m_phase = 0; m_k = 0; m_wcyc = 0; m_armed = 1'b0;
        m_we = '0; m_data = '0; m_addr = '0; m_start = 1'b0; m_fcnt = '0;
        compare_all();
        repeat (2) begin
            @(negedge iCLK);
            compare_all();
        end
        iADC_VALID = 1'b1;
        iADC_DATA  = 12'h5A5;
        iFHT_RDY   = 1'b0;
        iRESET     = 1'b1;
        prev_busy  = 1'b0;
        model_update(1'b1, 12'h5A5, 1'b0);
    endtask

    // gap: 3 = iFHT_RDY held high, 11 = single pulse 10 cycles after oSTART, 0 = random
    task automatic run_frame(input int mode, input int gap);
        logic [15:0] f0;
        logic v, r;
        logic [ADC_WIDTH-1:0] d;
        f0 = m_fcnt;
        start_cyc = -1;
        load_cyc  = -1;
        for (int i = 0; i < 3000 && m_fcnt == f0; i++) begin
            d = ADC_WIDTH'($urandom);
            if (m_phase == 0) begin
                case (mode)
                    0:       begin v = 1'b1; d = ADC_WIDTH'(m_k); end
                    1:       begin v = 1'b1; if (m_k < 4) d = spec_v[m_k]; end
                    2:       v = (cyc % 2 == 0);
                    default: v = ($urandom % 4 != 0);
                endcase
            end else begin
                v = (mode == 2) ? 1'b1 : 1'($urandom % 2);
            end
            if (gap == 3)       r = 1'b1;
            else if (gap == 11) r = (m_phase == 2 && m_wcyc == 10);
            else                r = 1'($urandom % 4 == 0);
            step(v, d, r);
        end
        step(1'b0, '0, 1'b0);
        chk("frame_done", 32'(m_fcnt != f0), 32'd1);
        if (gap != 0) chk("start_to_load", 32'(load_cyc - start_cyc), 32'(gap));
    endtask

    initial begin
        #3;
        do_reset();
        run_frame(0, 3);
        chk("fcnt_after_first", 32'(oFRAME_CNT), 32'd1);
        run_frame(1, 11);
        run_frame(2, 0);
        for (int i = 0; i < 200 && m_k < 13; i++) step(1'b1, ADC_WIDTH'($urandom), 1'b0);
        @(posedge iCLK);
        #2;
        do_reset();
        nstart = 0;
        run_frame(3, 0);
        chk("one_start_after_reset", 32'(nstart), 32'd1);
        repeat (3) run_frame(3, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
